// File: rtl/sdram_chk_pkg.sv
// Shared types and constants for the SDRAM write-then-verify Wishbone checker.
package sdram_chk_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_WDRAIN,
        S_READ,
        S_RDRAIN,
        S_FIN
    } state_t;

    localparam int ERR_W = 16;

    // Right-shifting Galois masks: x^16+x^14+x^13+x^11+1 and x^32+x^22+x^2+x+1
    localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
    localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

endpackage

// File: rtl/sdram_chk_pattern.sv
// Test-pattern generator: loads from seed, steps once per word index.
// SDRAM_CHK_LFSR_EN selects a maximal Galois LFSR instead of seed + i.
module sdram_chk_pattern
    import sdram_chk_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] seed,
    output logic [DW-1:0] value
);

    logic [DW-1:0] stepped;
    logic [DW-1:0] start_val;

`ifdef SDRAM_CHK_LFSR_EN
    localparam logic [DW-1:0] TAPS = (DW == 16) ? DW'(LFSR_TAPS_16) : DW'(LFSR_TAPS_32);

    always_comb begin
        stepped = value >> 1;
        if (value[0]) stepped = stepped ^ TAPS;
    end

    // An all-zero state would lock the LFSR up.
    assign start_val = (seed == '0) ? DW'(1) : seed;
`else
    assign stepped   = value + DW'(1);
    assign start_val = seed;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  value <= '0;
        else if (load) value <= start_val;
        else if (step) value <= stepped;
    end

endmodule

// File: rtl/sdram_wb_checker.sv
// Pipelined Wishbone memory checker: writes a pattern over NWORDS words,
// reads it back in order and counts mismatches.
module sdram_wb_checker
    import sdram_chk_pkg::*;
#(
    parameter int            DW        = 32,
    parameter int            AW        = 32,
    parameter int            NWORDS    = 256,
    parameter logic [AW-1:0] BASE_ADDR = '0,
    parameter int            MAX_OUT   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [DW-1:0]    seed,
    output logic             cyc_o,
    output logic             stb_o,
    output logic             we_o,
    output logic [AW-1:0]    addr_o,
    output logic [DW-1:0]    data_o,
    input  logic [DW-1:0]    data_i,
    input  logic             stall_i,
    input  logic             ack_i,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [AW-1:0]    err_addr
);

    localparam int            IW     = $clog2(NWORDS);
    localparam int            BS     = (DW == 16) ? 1 : 2;
    localparam logic [IW:0]   NW_CNT = (IW + 1)'(NWORDS);
    localparam logic [3:0]    MAX_L  = 4'(MAX_OUT);

    state_t           state;
    logic [IW-1:0]    idx, ack_idx, idx_nxt;
    logic [IW:0]      iss_cnt, iss_nxt;
    logic [3:0]       out_cnt, out_nxt;
    logic [DW-1:0]    cmp_value;
    logic [ERR_W-1:0] err_nxt;
    logic             start_ok, issue, ack_v, rd_ack, mismatch, room;

    function automatic logic [AW-1:0] word_addr(input logic [IW-1:0] i);
        return BASE_ADDR + (AW'(i) << BS);
    endfunction

    assign start_ok = (state == S_IDLE) && start;
    assign issue    = stb_o && !stall_i;
    // Acks with nothing outstanding are stray and must not underflow the counter.
    assign ack_v    = ack_i && (out_cnt != 4'd0);
    assign rd_ack   = ack_v && (state == S_READ || state == S_RDRAIN);
    assign out_nxt  = out_cnt + {3'd0, issue} - {3'd0, ack_v};
    assign iss_nxt  = iss_cnt + {{IW{1'b0}}, issue};
    assign idx_nxt  = idx + {{(IW-1){1'b0}}, issue};
    assign room     = (out_nxt < MAX_L) && (iss_nxt < NW_CNT);
    assign mismatch = rd_ack && (data_i != cmp_value);
    assign err_nxt  = (mismatch && err_cnt != '1) ? err_cnt + ERR_W'(1) : err_cnt;

    sdram_chk_pattern #(.DW(DW)) u_iss_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .step    (issue && state == S_WRITE),
        .seed    (seed),
        .value   (data_o)
    );

    sdram_chk_pattern #(.DW(DW)) u_cmp_pat (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (start_ok),
        .step    (rd_ack),
        .seed    (seed),
        .value   (cmp_value)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cyc_o    <= 1'b0;
            stb_o    <= 1'b0;
            we_o     <= 1'b0;
            addr_o   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            idx      <= '0;
            ack_idx  <= '0;
            iss_cnt  <= '0;
            out_cnt  <= '0;
        end else begin
            done    <= 1'b0;
            out_cnt <= out_nxt;
            case (state)
                S_IDLE: if (start) begin
                    state    <= S_WRITE;
                    cyc_o    <= 1'b1;
                    stb_o    <= 1'b1;
                    we_o     <= 1'b1;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    err_cnt  <= '0;
                    err_addr <= '0;
                    idx      <= '0;
                    ack_idx  <= '0;
                    iss_cnt  <= '0;
                    addr_o   <= BASE_ADDR;
                end
                S_WRITE, S_READ: begin
                    idx     <= idx_nxt;
                    iss_cnt <= iss_nxt;
                    stb_o   <= room;
                    if (issue) addr_o <= word_addr(idx_nxt);
                    if (iss_nxt == NW_CNT) state <= (state == S_WRITE) ? S_WDRAIN : S_RDRAIN;
                end
                // cyc_o stays up across the turnaround; the index has wrapped to 0.
                S_WDRAIN: if (out_nxt == 4'd0) begin
                    state   <= S_READ;
                    we_o    <= 1'b0;
                    stb_o   <= 1'b1;
                    iss_cnt <= '0;
                end
                S_RDRAIN: if (out_nxt == 4'd0) begin
                    state <= S_FIN;
                    cyc_o <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_nxt == '0);
                end
                S_FIN: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
            if (rd_ack) begin
                ack_idx <= ack_idx + {{(IW-1){1'b0}}, 1'b1};
                err_cnt <= err_nxt;
                if (mismatch && err_cnt == '0) err_addr <= word_addr(ack_idx);
            end
        end
    end

endmodule

// File: tb/tb_sdram_wb_checker.sv
// Scoreboard bench for sdram_wb_checker: Wishbone slave model with latency,
// stall and corruption knobs; request and done monitors pop expected queues.
module tb_sdram_wb_checker;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int NW = 16;
    localparam int MO = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] seed = '0;
    logic [DW-1:0] data_i = '0;
    logic          stall_i = 1'b0;
    logic          ack_i = 1'b0;
    logic          cyc_o, stb_o, we_o, busy, done, pass;
    logic [AW-1:0] addr_o, err_addr;
    logic [DW-1:0] data_o;
    logic [15:0]   err_cnt;

    always #5 clk = ~clk;

    sdram_wb_checker #(.DW(DW), .AW(AW), .NWORDS(NW), .MAX_OUT(MO)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .seed(seed),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
        .data_i(data_i), .stall_i(stall_i), .ack_i(ack_i),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .err_addr(err_addr)
    );

    typedef struct { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } req_t;
    typedef struct { logic ok; logic [15:0] cnt; logic [AW-1:0] addr; } res_t;
    typedef struct { int ready; logic we; int word; } slot_t;

    req_t  exp_req[$];
    res_t  exp_res[$];
    slot_t pend[$];

    int compared = 0;
    int mismatched = 0;
    int ncyc = 0, n_iss = 0, done_count = 0, max_out = 0;
    int lat = 0, stray_req = 0, stray_done = 0;
    bit saw_full = 1'b0;
    logic [NW-1:0] corrupt = '0;
    logic [DW-1:0] mem [NW];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pat(logic [DW-1:0] s, int i);
        logic [DW-1:0] v;
`ifdef SDRAM_CHK_LFSR_EN
        v = (s == '0) ? 32'd1 : s;
        for (int k = 0; k < i; k++) v = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
`else
        v = s + DW'(i);
`endif
        return v;
    endfunction

    // Slave model and request scoreboard; runs on the falling edge.
    always @(negedge clk) begin
        slot_t p;
        req_t  e;
        int    w;
        ncyc++;
        if (!reset_n) begin
            pend.delete();
            ack_i  = 1'b0;
            data_i = '0;
        end else begin
            if (lat == 3) begin
                if (pend.size() > max_out) max_out = pend.size();
                if (pend.size() == MO && cyc_o && !stb_o) saw_full = 1'b1;
            end
            if (cyc_o && stb_o && !stall_i) begin
                n_iss++;
                w = int'(addr_o[AW-1:2]) % NW;
                if (exp_req.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_request: addr %0h we %0b", addr_o, we_o);
                end else begin
                    e = exp_req.pop_front();
                    chk("req_we", 64'(we_o), 64'(e.we));
                    chk("req_addr", 64'(addr_o), 64'(e.addr));
                    if (e.we) chk("wr_data", 64'(data_o), 64'(e.data));
                end
                if (we_o) mem[w] = data_o;
                pend.push_back('{ready: ncyc + 1 + lat, we: we_o, word: w});
            end
            ack_i  = 1'b0;
            data_i = '0;
            if (pend.size() > 0 && pend[0].ready <= ncyc) begin
                p = pend.pop_front();
                ack_i = 1'b1;
                if (!p.we) data_i = mem[p.word] ^ (corrupt[p.word] ? 32'hDEAD_0000 : 32'h0);
            end else if (stray_req != stray_done && pend.size() == 0) begin
                stray_done = stray_req;
                ack_i = 1'b1;
            end
        end
    end

    // Result monitor.
    always @(negedge clk) begin
        if (reset_n && done) begin
            res_t r;
            done_count++;
            if (exp_res.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_done: pass %0b err_cnt %0d", pass, err_cnt);
            end else begin
                r = exp_res.pop_front();
                chk("done_pass", 64'(pass), 64'(r.ok));
                chk("done_err_cnt", 64'(err_cnt), 64'(r.cnt));
                chk("done_err_addr", 64'(err_addr), 64'(r.addr));
            end
        end
    end

    task automatic push_expect(logic [DW-1:0] s, logic ok, logic [15:0] cnt, logic [AW-1:0] ea);
        for (int i = 0; i < NW; i++) exp_req.push_back('{we: 1'b1, addr: AW'(i * 4), data: pat(s, i)});
        for (int i = 0; i < NW; i++) exp_req.push_back('{we: 1'b0, addr: AW'(i * 4), data: '0});
        exp_res.push_back('{ok: ok, cnt: cnt, addr: ea});
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        exp_req.delete();
        exp_res.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic pulse_start(string name, logic [DW-1:0] s);
        @(posedge clk);
        #1 start = 1'b1;
        seed = s;
        @(posedge clk);
        #1 start = 1'b0;
        chk({name, "_stb_rise"}, 64'({stb_o, cyc_o, we_o, busy}), 64'(4'b1111));
        chk({name, "_clear"}, 64'({pass, err_cnt}), 64'(0));
        chk({name, "_first_word"}, 64'(data_o), 64'(pat(s, 0)));
    endtask

    task automatic wait_done(string name);
        int d0 = done_count;
        int t = 0;
        while (done_count == d0 && t < 3000) begin
            @(posedge clk);
            t++;
        end
        if (done_count == d0) begin
            compared++;
            mismatched++;
            $display("FAIL %s_timeout: no done after %0d cycles", name, t);
            apply_reset();
        end else begin
            #1 chk({name, "_idle"}, 64'({busy, cyc_o, stb_o}), 64'(0));
        end
    endtask

    task automatic wait_until_issued(string name, int target);
        int t = 0;
        while (n_iss < target && t < 500) begin
            @(posedge clk);
            t++;
        end
        if (n_iss < target) begin
            compared++;
            mismatched++;
            $display("FAIL %s_issue_timeout: issued %0d needed %0d", name, n_iss, target);
        end
    endtask

    initial begin
        logic [AW-1:0] a0;
        int d0, t;
        for (int i = 0; i < NW; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctl", 64'({cyc_o, stb_o, we_o, busy, done, pass}), 64'(0));
        chk("reset_addr_data", {addr_o, data_o}, 64'(0));
        chk("reset_err", 64'({err_cnt, err_addr}), 64'(0));
        reset_n = 1'b1;

        // Zero-wait slave, seed 0x100.
        push_expect(32'h100, 1'b1, 16'd0, '0);
        pulse_start("zero_wait", 32'h100);
        wait_done("zero_wait");

        // Stray ack while idle, then a pass with a 5-cycle stall and an ignored start.
        stray_req++;
        repeat (3) @(posedge clk);
        push_expect(32'hA5A5_0000, 1'b1, 16'd0, '0);
        d0 = n_iss;
        pulse_start("stall", 32'hA5A5_0000);
        wait_until_issued("stall", d0 + 6);
        @(posedge clk);
        #2 stall_i = 1'b1;
        a0 = addr_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2 chk("stall_hold_addr", 64'(addr_o), 64'(a0));
        end
        stall_i = 1'b0;
        @(posedge clk);
        #2 start = 1'b1;
        seed = 32'h5555_5555;
        @(posedge clk);
        #2 start = 1'b0;
        wait_done("stall");

        // Slave acking 3 cycles late against MAX_OUT=2.
        lat = 3;
        push_expect(32'h1234_5678, 1'b1, 16'd0, '0);
        pulse_start("late_ack", 32'h1234_5678);
        wait_done("late_ack");
        chk("late_max_outstanding", 64'(max_out), 64'(2));
        chk("late_stb_drop_full", 64'(saw_full), 64'(1));
        lat = 0;

        // Corrupt words 5 and 9 on read-back.
        corrupt = 16'h0220;
        push_expect(32'h0000_0040, 1'b0, 16'd2, 32'h14);
        pulse_start("corrupt", 32'h0000_0040);
        wait_done("corrupt");
        corrupt = '0;

        // Reset during READ, then a clean pass.
        push_expect(32'h0F0F_0F0F, 1'b1, 16'd0, '0);
        pulse_start("rst_mid", 32'h0F0F_0F0F);
        t = 0;
        while (!(cyc_o && !we_o && busy) && t < 500) begin
            @(posedge clk);
            #1 t++;
        end
        chk("rst_mid_reached_read", 64'({cyc_o, we_o}), 64'(2'b10));
        repeat (3) @(posedge clk);
        d0 = done_count;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_ctl", 64'({cyc_o, stb_o, we_o, busy, done, pass}), 64'(0));
        chk("rst_mid_addr_data", {addr_o, data_o}, 64'(0));
        chk("rst_mid_err", 64'({err_cnt, err_addr}), 64'(0));
        apply_reset();
        chk("rst_mid_no_done", 64'(done_count), 64'(d0));
        push_expect(32'h7777_0000, 1'b1, 16'd0, '0);
        pulse_start("after_rst", 32'h7777_0000);
        wait_done("after_rst");

        // Zero seed (LFSR build starts at state 1).
        push_expect(32'h0, 1'b1, 16'd0, '0);
        pulse_start("seed_zero", 32'h0);
        wait_done("seed_zero");

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
